// File: rtl/mp_link_pkg.sv
// Shared definitions for the processor link bridge.
//   state_t   : TX sequencer states
//   DEF_*     : default parameter values
//   cnt_w()   : width of an occupancy counter able to hold 0..n
package mp_link_pkg;

   localparam int DEF_DATA_W      = 8;
   localparam int DEF_FIFO_DEPTH  = 16;
   localparam int DEF_LOAD_CYC    = 2;
   localparam int DEF_TIMEOUT_CYC = 1024;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOAD      = 2'd1,
      ST_WAIT_SENT = 2'd2
   } state_t;

   function automatic int cnt_w(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/mp_link_fifo.sv
// Synchronous show-ahead FIFO.
//   i_clk, i_rst      : clock, synchronous active-high reset (flushes pointers)
//   i_push, i_data    : write request and word; accepted when not full, or when
//                       full and popped in the same cycle
//   i_pop             : read request; ignored when empty
//   o_data            : head word, valid while o_empty is low
//   o_full, o_empty   : status
//   o_count           : exact occupancy 0..DEPTH
module mp_link_fifo
   import mp_link_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_FIFO_DEPTH
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_push,
   input  logic [DATA_W-1:0]       i_data,
   input  logic                    i_pop,
   output logic [DATA_W-1:0]       o_data,
   output logic                    o_full,
   output logic                    o_empty,
   output logic [cnt_w(DEPTH)-1:0] o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW:0]       r_wr_ptr;
   logic [AW:0]       r_rd_ptr;
   logic              w_do_push;
   logic              w_do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign o_count   = r_wr_ptr - r_rd_ptr;
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (o_count == (AW+1)'(DEPTH));
   assign o_data    = r_mem[r_rd_ptr[AW-1:0]];
   assign w_do_pop  = i_pop & ~o_empty;
   // When full, the slot being written is the one being read this cycle.
   assign w_do_push = i_push & (~o_full | w_do_pop);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/mp_link_bridge.sv
// Bridge between the on-chip processor streaming ports and the external
// asynchronous processor link.
//   clk_clk, reset_reset        : clock, synchronous active-high reset
//   tx_data/tx_valid/tx_ready   : outbound words from the CPU into the TX FIFO
//   rx_data/rx_valid/rx_ready   : inbound words from the RX FIFO to the CPU
//   mpdatain_export/chrec_export: async inbound word and its strobe
//   mpdataout_export/load_export/asoe_export/sent_export : outbound link
//   clr_err                     : clears rx_overflow and tx_timeout
//   rx_count/tx_count           : FIFO occupancy
//
// TX sequencer states:
//   state        | meaning
//   ST_IDLE      | link released; pop next TX word when one is queued
//   ST_LOAD      | word driven, load strobe high for LOAD_CYC cycles
//   ST_WAIT_SENT | word driven, waiting for sent edge or timeout
module mp_link_bridge
   import mp_link_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
   parameter int LOAD_CYC    = DEF_LOAD_CYC,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic                         clk_clk,
   input  logic                         reset_reset,
   input  logic [DATA_W-1:0]            tx_data,
   input  logic                         tx_valid,
   output logic                         tx_ready,
   output logic [DATA_W-1:0]            rx_data,
   output logic                         rx_valid,
   input  logic                         rx_ready,
   input  logic [DATA_W-1:0]            mpdatain_export,
   input  logic                         chrec_export,
   output logic [DATA_W-1:0]            mpdataout_export,
   output logic                         load_export,
   output logic                         asoe_export,
   input  logic                         sent_export,
   input  logic                         clr_err,
   output logic                         rx_overflow,
   output logic                         tx_timeout,
   output logic [cnt_w(FIFO_DEPTH)-1:0] rx_count,
   output logic [cnt_w(FIFO_DEPTH)-1:0] tx_count
);

   localparam int TMR_MAX = (LOAD_CYC > TIMEOUT_CYC) ? LOAD_CYC : TIMEOUT_CYC;
   localparam int TMR_W   = cnt_w(TMR_MAX);
   localparam logic [TMR_W-1:0] LOAD_INIT = TMR_W'(LOAD_CYC - 1);
   localparam logic [TMR_W-1:0] TMO_INIT  = TMR_W'(TIMEOUT_CYC - 1);

   // synchronisers (s3 is the previous synced value for edge detection)
   logic              r_chrec_s1, r_chrec_s2, r_chrec_s3;
   logic              r_sent_s1, r_sent_s2, r_sent_s3;
   logic [DATA_W-1:0] r_data_s1, r_data_s2;
   logic              w_chrec_rise;
   logic              w_sent_rise;

   logic              r_rx_push;
   logic [DATA_W-1:0] r_rx_word;
   logic              w_rx_pop;
   logic              w_rx_full;
   logic              w_rx_empty;

   logic              w_tx_push;
   logic              w_tx_pop;
   logic              w_tx_full;
   logic              w_tx_empty;
   logic [DATA_W-1:0] w_tx_head;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [TMR_W-1:0]  r_tmr;
   logic [DATA_W-1:0] r_out_word;
   logic              w_timeout_evt;
   logic              w_ovf_evt;
   logic              r_rx_overflow;
   logic              r_tx_timeout;

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         r_chrec_s1 <= 1'b0;
         r_chrec_s2 <= 1'b0;
         r_chrec_s3 <= 1'b0;
         r_sent_s1  <= 1'b0;
         r_sent_s2  <= 1'b0;
         r_sent_s3  <= 1'b0;
         r_data_s1  <= '0;
         r_data_s2  <= '0;
         r_rx_push  <= 1'b0;
         r_rx_word  <= '0;
      end else begin
         r_chrec_s1 <= chrec_export;
         r_chrec_s2 <= r_chrec_s1;
         r_chrec_s3 <= r_chrec_s2;
         r_sent_s1  <= sent_export;
         r_sent_s2  <= r_sent_s1;
         r_sent_s3  <= r_sent_s2;
         r_data_s1  <= mpdatain_export;
         r_data_s2  <= r_data_s1;
         // Word and strobe travel the same sync path, so the captured word
         // is the one present when chrec was first sampled high.
         r_rx_push  <= w_chrec_rise;
         r_rx_word  <= r_data_s2;
      end
   end

   assign w_chrec_rise = r_chrec_s2 & ~r_chrec_s3;
   assign w_sent_rise  = r_sent_s2 & ~r_sent_s3;

   assign rx_valid  = ~w_rx_empty;
   assign w_rx_pop  = rx_valid & rx_ready;
   assign w_ovf_evt = r_rx_push & w_rx_full & ~w_rx_pop;

   mp_link_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .i_clk   (clk_clk),
      .i_rst   (reset_reset),
      .i_push  (r_rx_push),
      .i_data  (r_rx_word),
      .i_pop   (w_rx_pop),
      .o_data  (rx_data),
      .o_full  (w_rx_full),
      .o_empty (w_rx_empty),
      .o_count (rx_count)
   );

   assign tx_ready  = ~w_tx_full;
   assign w_tx_push = tx_valid & tx_ready;

   mp_link_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .i_clk   (clk_clk),
      .i_rst   (reset_reset),
      .i_push  (w_tx_push),
      .i_data  (tx_data),
      .i_pop   (w_tx_pop),
      .o_data  (w_tx_head),
      .o_full  (w_tx_full),
      .o_empty (w_tx_empty),
      .o_count (tx_count)
   );

   always_ff @(posedge clk_clk) begin
      if (reset_reset) r_state <= ST_IDLE;
      else             r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:      if (!w_tx_empty) w_state_nxt = ST_LOAD;
         ST_LOAD:      if (r_tmr == '0) w_state_nxt = ST_WAIT_SENT;
         ST_WAIT_SENT: if (w_sent_rise || (r_tmr == '0)) w_state_nxt = ST_IDLE;
         default:      w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      asoe_export      = (r_state != ST_IDLE);
      load_export      = (r_state == ST_LOAD);
      mpdataout_export = asoe_export ? r_out_word : '0;
      w_tx_pop         = (r_state == ST_IDLE) & ~w_tx_empty;
      // An acknowledge arriving on the last waiting cycle still counts.
      w_timeout_evt    = (r_state == ST_WAIT_SENT) & ~w_sent_rise & (r_tmr == '0);
   end

   // Shared down-counter: load phase length, then sent timeout.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         r_tmr <= '0;
      end else begin
         case (r_state)
            ST_IDLE:      r_tmr <= LOAD_INIT;
            ST_LOAD:      r_tmr <= (r_tmr == '0) ? TMO_INIT : r_tmr - TMR_W'(1);
            ST_WAIT_SENT: r_tmr <= (r_tmr == '0) ? '0 : r_tmr - TMR_W'(1);
            default:      r_tmr <= '0;
         endcase
      end
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset)        r_out_word <= '0;
      else if (w_tx_pop)      r_out_word <= w_tx_head;
      else if (w_timeout_evt) r_out_word <= '0;
   end

   // Sticky errors; a new event in the clearing cycle keeps the flag set.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         r_rx_overflow <= 1'b0;
         r_tx_timeout  <= 1'b0;
      end else begin
         r_rx_overflow <= w_ovf_evt     | (r_rx_overflow & ~clr_err);
         r_tx_timeout  <= w_timeout_evt | (r_tx_timeout  & ~clr_err);
      end
   end

   assign rx_overflow = r_rx_overflow;
   assign tx_timeout  = r_tx_timeout;

endmodule

// File: tb/tb_mp_link_bridge.sv
module tb_mp_link_bridge;

   localparam int DW  = 8;
   localparam int DEP = 16;
   localparam int CW  = $clog2(DEP) + 1;

   logic          clk_clk;
   logic          reset_reset;
   logic [DW-1:0] tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic [DW-1:0] mpdatain_export;
   logic          chrec_export;
   logic [DW-1:0] mpdataout_export;
   logic          load_export;
   logic          asoe_export;
   logic          sent_export;
   logic          clr_err;
   logic          rx_overflow;
   logic          tx_timeout;
   logic [CW-1:0] rx_count;
   logic [CW-1:0] tx_count;

   mp_link_bridge #(
      .DATA_W(DW), .FIFO_DEPTH(DEP), .LOAD_CYC(2), .TIMEOUT_CYC(8)
   ) dut (
      .clk_clk          (clk_clk),
      .reset_reset      (reset_reset),
      .tx_data          (tx_data),
      .tx_valid         (tx_valid),
      .tx_ready         (tx_ready),
      .rx_data          (rx_data),
      .rx_valid         (rx_valid),
      .rx_ready         (rx_ready),
      .mpdatain_export  (mpdatain_export),
      .chrec_export     (chrec_export),
      .mpdataout_export (mpdataout_export),
      .load_export      (load_export),
      .asoe_export      (asoe_export),
      .sent_export      (sent_export),
      .clr_err          (clr_err),
      .rx_overflow      (rx_overflow),
      .tx_timeout       (tx_timeout),
      .rx_count         (rx_count),
      .tx_count         (tx_count)
   );

   initial clk_clk = 1'b0;
   always #5 clk_clk = ~clk_clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0] txq[$];
   logic [DW-1:0] rxq[$];

   typedef struct {
      logic [DW-1:0] word;
      int            sent_delay;
      bit            exp_timeout;
      bit            early_sent;
   } tx_vec_t;

   tx_vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_clk);
      #1;
   endtask

   // Outbound scoreboard: each new load strobe must carry the next queued word.
   logic prev_load = 1'b0;
   always @(negedge clk_clk) begin
      if (load_export === 1'b1 && prev_load === 1'b0) begin
         if (txq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL tx_word: got 0x%0h expected none queued", mpdataout_export);
         end else begin
            check("tx_word", 32'(mpdataout_export), 32'(txq.pop_front()));
         end
      end
      prev_load <= load_export;
   end

   task automatic rx_pulse(input logic [DW-1:0] d);
      mpdatain_export = d;
      chrec_export    = 1'b1;
      step();
      chrec_export    = 1'b0;
      step();
      step();
   endtask

   task automatic rx_read();
      logic [DW-1:0] exp;
      if (rxq.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL rx_read: got 0x%0h expected none queued", rx_data);
      end else begin
         exp = rxq.pop_front();
         check("rx_valid", 32'(rx_valid), 32'd1);
         check("rx_data", 32'(rx_data), 32'(exp));
      end
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
   endtask

   task automatic wait_sent_ack(input string name);
      int t = 0;
      while (asoe_export && t < 12) begin
         step();
         t++;
      end
      check(name, 32'(asoe_export), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{word: 8'hA5, sent_delay: 0, exp_timeout: 1'b0, early_sent: 1'b0};
      vecs[1] = '{word: 8'h5A, sent_delay: 1, exp_timeout: 1'b0, early_sent: 1'b0};
      vecs[2] = '{word: 8'hFF, sent_delay: 3, exp_timeout: 1'b0, early_sent: 1'b0};
      vecs[3] = '{word: 8'h00, sent_delay: 0, exp_timeout: 1'b1, early_sent: 1'b0};
      vecs[4] = '{word: 8'h3C, sent_delay: 0, exp_timeout: 1'b1, early_sent: 1'b1};

      reset_reset = 1'b1;
      tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
      mpdatain_export = '0; chrec_export = 1'b0;
      sent_export = 1'b0; clr_err = 1'b0;
      repeat (3) step();
      check("rst_tx_ready", 32'(tx_ready), 32'd1);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_asoe", 32'(asoe_export), 32'd0);
      check("rst_load", 32'(load_export), 32'd0);
      check("rst_dout", 32'(mpdataout_export), 32'd0);
      check("rst_counts", 32'({rx_count, tx_count}), 32'd0);
      check("rst_errs", 32'({rx_overflow, tx_timeout}), 32'd0);
      reset_reset = 1'b0;
      step();

      // TX table
      for (int v = 0; v < 5; v++) begin
         tx_data  = vecs[v].word;
         tx_valid = 1'b1;
         if (vecs[v].early_sent) sent_export = 1'b1;
         txq.push_back(vecs[v].word);
         step();
         tx_valid    = 1'b0;
         sent_export = 1'b0;
         check("tx_count_push", 32'(tx_count), 32'd1);
         check("asoe_pre", 32'(asoe_export), 32'd0);
         step();
         check("asoe_load1", 32'(asoe_export), 32'd1);
         check("load_1", 32'(load_export), 32'd1);
         check("dout", 32'(mpdataout_export), 32'(vecs[v].word));
         check("tx_count_pop", 32'(tx_count), 32'd0);
         step();
         check("load_2", 32'(load_export), 32'd1);
         step();
         check("load_end", 32'(load_export), 32'd0);
         check("asoe_wait", 32'(asoe_export), 32'd1);
         if (!vecs[v].exp_timeout) begin
            repeat (vecs[v].sent_delay) step();
            sent_export = 1'b1;
            wait_sent_ack("sent_ack");
            sent_export = 1'b0;
            check("no_timeout", 32'(tx_timeout), 32'd0);
         end else begin
            for (int i = 1; i <= 8; i++) begin
               step();
               check("tmo_flag", 32'(tx_timeout), 32'(i == 8));
               check("tmo_asoe", 32'(asoe_export), 32'(i != 8));
            end
            clr_err = 1'b1;
            step();
            clr_err = 1'b0;
            check("tmo_clear", 32'(tx_timeout), 32'd0);
         end
         repeat (3) step();
      end

      // Timeout with a second word queued; clr_err held across the timeout edge
      tx_data = 8'h11; tx_valid = 1'b1; txq.push_back(8'h11);
      step();
      tx_data = 8'h22; txq.push_back(8'h22);
      step();
      tx_valid = 1'b0;
      check("q2_count", 32'(tx_count), 32'd1);
      step();
      step();
      clr_err = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         check("q2_tmo", 32'(tx_timeout), 32'(i == 8));
      end
      step();
      clr_err = 1'b0;
      check("q2_tmo_cleared", 32'(tx_timeout), 32'd0);
      check("q2_load", 32'(load_export), 32'd1);
      check("q2_dout", 32'(mpdataout_export), 32'h22);
      check("q2_count0", 32'(tx_count), 32'd0);
      step();
      step();
      sent_export = 1'b1;
      wait_sent_ack("q2_sent_ack");
      sent_export = 1'b0;
      repeat (3) step();

      // RX single word with held strobe
      mpdatain_export = 8'h3C;
      chrec_export    = 1'b1;
      rxq.push_back(8'h3C);
      for (int i = 1; i <= 4; i++) begin
         step();
         check("rx_latency", 32'(rx_valid), 32'(i >= 4));
      end
      chrec_export = 1'b0;
      repeat (6) step();
      check("rx_one_word", 32'(rx_count), 32'd1);
      rx_read();
      check("rx_empty", 32'(rx_valid), 32'd0);
      check("rx_count0", 32'(rx_count), 32'd0);

      // RX overflow
      for (int i = 0; i < 16; i++) begin
         rx_pulse(8'(i * 13 + 7));
         rxq.push_back(8'(i * 13 + 7));
      end
      repeat (4) step();
      check("full_count", 32'(rx_count), 32'd16);
      check("full_no_ovf", 32'(rx_overflow), 32'd0);
      rx_pulse(8'h99);
      repeat (4) step();
      check("ovf_count", 32'(rx_count), 32'd16);
      check("ovf_flag", 32'(rx_overflow), 32'd1);
      for (int i = 0; i < 16; i++) rx_read();
      check("ovf_drained", 32'(rx_count), 32'd0);
      check("ovf_sticky", 32'(rx_overflow), 32'd1);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      check("ovf_clear", 32'(rx_overflow), 32'd0);

      // Push and pop in the same cycle while full
      for (int i = 0; i < 16; i++) begin
         rx_pulse(8'(8'hF0 - i));
         rxq.push_back(8'(8'hF0 - i));
      end
      repeat (4) step();
      check("full2_count", 32'(rx_count), 32'd16);
      mpdatain_export = 8'hE7;
      chrec_export    = 1'b1;
      step();
      chrec_export = 1'b0;
      step();
      step();
      rxq.push_back(8'hE7);
      rx_read();
      check("pp_count", 32'(rx_count), 32'd16);
      check("pp_no_ovf", 32'(rx_overflow), 32'd0);
      for (int i = 0; i < 16; i++) rx_read();
      check("pp_drained", 32'(rx_count), 32'd0);

      // Reset while in LOAD with words queued
      tx_valid = 1'b1;
      tx_data = 8'hC1; txq.push_back(8'hC1); step();
      tx_data = 8'hC2; txq.push_back(8'hC2); step();
      tx_data = 8'hC3; txq.push_back(8'hC3); step();
      tx_valid = 1'b0;
      check("mid_load", 32'(load_export), 32'd1);
      check("mid_count", 32'(tx_count), 32'd2);
      reset_reset = 1'b1;
      step();
      check("mr_load", 32'(load_export), 32'd0);
      check("mr_asoe", 32'(asoe_export), 32'd0);
      check("mr_count", 32'(tx_count), 32'd0);
      check("mr_dout", 32'(mpdataout_export), 32'd0);
      reset_reset = 1'b0;
      txq.delete();
      repeat (4) step();
      check("mr_idle_asoe", 32'(asoe_export), 32'd0);
      check("mr_idle_count", 32'(tx_count), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mp_link_bridge.md
Name: mp_link_bridge

Overview:
- Parametrised successor to the single-byte Nios/micro-processor handshake interface (mpdatain/chrec, mpdataout/load/sent, asoe).
- Generalised to DATA_W-wide words with independent RX/TX FIFOs of configurable depth.
- Adds input synchronisation, sent timeout with sticky error, RX overflow detection and fill counters.
- Sits between the on-chip processor's streaming ports and the external asynchronous processor link.

Parameters:
- DATA_W, 8, link word width in bits.
- FIFO_DEPTH, 16, entries per FIFO; power of two, ≥2.
- LOAD_CYC, 2, cycles load_export is held high per word; ≥1.
- TIMEOUT_CYC, 1024, cycles WAIT_SENT waits for sent before aborting; ≥1.

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  synchronous, active-high reset.
- tx_data  in  DATA_W  word from CPU side.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  TX FIFO not full.
- rx_data  out  DATA_W  head of RX FIFO, show-ahead.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  CPU consumes rx_data.
- mpdatain_export  in  DATA_W  async inbound word.
- chrec_export  in  1  async "character received" strobe, active high.
- mpdataout_export  out  DATA_W  outbound word.
- load_export  out  1  outbound load strobe.
- asoe_export  out  1  outbound drive enable.
- sent_export  in  1  async "word sent" acknowledge, active high.
- clr_err  in  1  clears sticky errors.
- rx_overflow  out  1  sticky: inbound word dropped.
- tx_timeout  out  1  sticky: sent never arrived.
- rx_count  out  $clog2(FIFO_DEPTH)+1  RX fill level.
- tx_count  out  $clog2(FIFO_DEPTH)+1  TX fill level.

Behaviour:
- Reset: all FIFOs empty; FSM IDLE; outputs low/zero; tx_ready=1; counts 0; sync flops cleared.
- Synchronisation: chrec_export, sent_export and mpdatain_export pass through 2-flop synchronisers. Rising edges are detected on the synchronised value (previous low, current high).
- RX: chrec_export is first sampled high at edge k; the word is written at edge k+3, and rx_valid is high after edge k+3.
  - If the RX FIFO is full at the write cycle, the word is dropped and rx_overflow is set; stored data is unchanged.
  - A held-high chrec produces one write only.
- RX pop: occurs on rx_valid & rx_ready. A push and pop in the same cycle keep the count and are legal even when full, so no overflow is flagged.
- TX push: occurs on tx_valid & tx_ready. A word pushed at edge n is visible to the FSM at edge n+1.
- TX FSM:
  - IDLE: if the TX FIFO is non-empty, pop the head into an output register and go to LOAD. asoe_export=1 and mpdataout_export=word from the next cycle.
  - LOAD: load_export=1 for exactly LOAD_CYC cycles, then go to WAIT_SENT.
  - WAIT_SENT: asoe stays 1, load=0, and a counter runs from 0.
    - Synced sent rising edge: go to IDLE, with asoe=0 the following cycle.
    - Counter reaches TIMEOUT_CYC-1: set tx_timeout, discard the word, go to IDLE.
  - A sent edge outside WAIT_SENT is ignored.
- Errors: rx_overflow and tx_timeout are sticky and cleared by clr_err. If a set event and clr_err coincide, set wins.
- Counts: rx_count/tx_count are exact occupancy, 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH, with the extra bit used to distinguish full from empty.
- Reset mid-transfer: returns to IDLE immediately, drops load/asoe, flushes both FIFOs; no partial word is retained.

Decomposition:
- Package mp_link_pkg:
  - FSM state enum (IDLE, LOAD, WAIT_SENT).
  - Default parameter constants.
  - Count-width function.
- One sub-module, mp_link_fifo: synchronous show-ahead FIFO (DATA_W, DEPTH, push/pop/full/empty/count). Instantiated twice.
- Synchronisers and FSM are inline.

Test Plan:
- Reset, then push 0xA5 with tx_valid for 1 cycle → after 1 cycle asoe=1, mpdataout=0xA5, load high 2 cycles. Pulse sent → asoe=0; tx_count 1→0.
- mpdatain=0x3C, chrec high 4 cycles → exactly one RX word 0x3C. rx_valid rises 3 edges after first sample. rx_count=1; rx_ready pop → rx_valid=0.
- With rx_ready=0, inject 17 chrec pulses (FIFO_DEPTH=16) → rx_count=16, rx_overflow=1, first 16 words read back in order. clr_err → rx_overflow=0.
- Push 0x11, never assert sent (TIMEOUT_CYC=8) → tx_timeout=1 exactly 8 cycles into WAIT_SENT; next queued word 0x22 then starts LOAD.
- RX FIFO full while chrec pulse arrives in the same cycle as rx_ready pop → no overflow, count stays 16, newest word at tail.
- Assert reset_reset during LOAD with 3 words queued → next cycle load=0, asoe=0, tx_count=0, state IDLE.
